// File: rtl/dest_track.sv
// dest_track: destination/write-enable tracker for the EX, MEM and WB stages,
// with an optional load-use interlock.
// Build macro DEST_TRACK_LOAD_STALL_EN enables the load-use stall and its
// saturating event counter; without it stall and stall_cnt are tied to 0.
module dest_track #(
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             id_valid,
   input  logic [3:0]       id_rd,
   input  logic             id_wr,
   input  logic             id_load,
   input  logic [3:0]       id_A,
   input  logic [3:0]       id_B,
   input  logic             flush,
   output logic [3:0]       ex_rd,
   output logic [3:0]       mem_rd,
   output logic [3:0]       wb_rd,
   output logic             ctrl_ex,
   output logic             ctrl_mem,
   output logic             ctrl_wb,
   output logic             ex_load,
   output logic             stall,
   output logic [CNT_W-1:0] stall_cnt
);

   logic [3:0] ex_rd_q, ex_rd_d;
   logic       ex_ctrl_q, ex_ctrl_d;
   logic       ex_load_q, ex_load_d;
   logic [3:0] mem_rd_q, wb_rd_q;
   logic       mem_ctrl_q, wb_ctrl_q;
   logic       stall_w;

`ifdef DEST_TRACK_LOAD_STALL_EN
   logic             hazard;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   // Load in EX whose result is needed by the decoding instruction; a single
   // compare per source, so id_A==id_B still yields one hazard.
   always_comb begin
      hazard = ex_ctrl_q & ex_load_q & id_valid &
               ((ex_rd_q == id_A) | (ex_rd_q == id_B));
      stall_w = hazard & ~flush;
   end

   // Stall-event counter, saturating at all-ones.
   always_comb begin
      cnt_d = cnt_q;
      if (stall_w && (cnt_q != {CNT_W{1'b1}}))
         cnt_d = cnt_q + 1'b1;
   end

   // Counter register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) cnt_q <= '0;
      else        cnt_q <= cnt_d;
   end

   assign stall_cnt = cnt_q;
`else
   // Loads complete in EX in this build: no interlock, sources are not needed.
   logic unused_src;
   assign unused_src = ^{id_A, id_B};
   assign stall_w    = 1'b0;
   assign stall_cnt  = '0;
`endif

   // EX slot next state: flush wins over stall, both insert a bubble.
   always_comb begin
      ex_rd_d   = id_rd;
      ex_ctrl_d = id_wr & id_valid;
      ex_load_d = id_load & id_valid;
      if (flush || stall_w) begin
         ex_rd_d   = 4'd0;
         ex_ctrl_d = 1'b0;
         ex_load_d = 1'b0;
      end
   end

   // Slot registers; MEM and WB advance every cycle, even during a stall,
   // so the offending load leaves EX and one stall cycle is enough.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ex_rd_q    <= 4'd0;
         ex_ctrl_q  <= 1'b0;
         ex_load_q  <= 1'b0;
         mem_rd_q   <= 4'd0;
         mem_ctrl_q <= 1'b0;
         wb_rd_q    <= 4'd0;
         wb_ctrl_q  <= 1'b0;
      end else begin
         ex_rd_q    <= ex_rd_d;
         ex_ctrl_q  <= ex_ctrl_d;
         ex_load_q  <= ex_load_d;
         mem_rd_q   <= ex_rd_q;
         mem_ctrl_q <= ex_ctrl_q;
         wb_rd_q    <= mem_rd_q;
         wb_ctrl_q  <= mem_ctrl_q;
      end
   end

   assign ex_rd    = ex_rd_q;
   assign ctrl_ex  = ex_ctrl_q;
   assign ex_load  = ex_load_q;
   assign mem_rd   = mem_rd_q;
   assign ctrl_mem = mem_ctrl_q;
   assign wb_rd    = wb_rd_q;
   assign ctrl_wb  = wb_ctrl_q;
   assign stall    = stall_w;

endmodule

// File: tb/tb_dest_track.sv
// tb_dest_track: directed and random checks of dest_track against a
// pipeline-of-entries reference model.
module tb_dest_track;
   localparam int CNT_W = 2;
`ifdef DEST_TRACK_LOAD_STALL_EN
   localparam bit EN = 1'b1;
`else
   localparam bit EN = 1'b0;
`endif
   localparam logic [CNT_W-1:0] CMAX = {CNT_W{1'b1}};

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic id_valid = 0, id_wr = 0, id_load = 0, flush = 0;
   logic [3:0] id_rd = 0, id_A = 0, id_B = 0;
   logic [3:0] ex_rd, mem_rd, wb_rd;
   logic ctrl_ex, ctrl_mem, ctrl_wb, ex_load, stall;
   logic [CNT_W-1:0] stall_cnt;

   dest_track #(.CNT_W(CNT_W)) dut (
      .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rd(id_rd),
      .id_wr(id_wr), .id_load(id_load), .id_A(id_A), .id_B(id_B),
      .flush(flush), .ex_rd(ex_rd), .mem_rd(mem_rd), .wb_rd(wb_rd),
      .ctrl_ex(ctrl_ex), .ctrl_mem(ctrl_mem), .ctrl_wb(ctrl_wb),
      .ex_load(ex_load), .stall(stall), .stall_cnt(stall_cnt));

   always #5 clk = ~clk;

   typedef struct { logic [3:0] rd; logic wr; logic ld; } ent_t;
   ent_t pipe [3];          // 0=EX 1=MEM 2=WB
   int   m_cnt;
   int   checks = 0, failures = 0;
   logic obs_stall, prev_stall;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 3; i++) pipe[i] = '{4'd0, 1'b0, 1'b0};
      m_cnt = 0;
      prev_stall = 1'b0;
   endtask

   task automatic chk_outputs(input string tag);
      chk({tag, ".ex_rd"},    {28'd0, ex_rd},    {28'd0, pipe[0].rd});
      chk({tag, ".ctrl_ex"},  {31'd0, ctrl_ex},  {31'd0, pipe[0].wr});
      chk({tag, ".ex_load"},  {31'd0, ex_load},  {31'd0, pipe[0].ld});
      chk({tag, ".mem_rd"},   {28'd0, mem_rd},   {28'd0, pipe[1].rd});
      chk({tag, ".ctrl_mem"}, {31'd0, ctrl_mem}, {31'd0, pipe[1].wr});
      chk({tag, ".wb_rd"},    {28'd0, wb_rd},    {28'd0, pipe[2].rd});
      chk({tag, ".ctrl_wb"},  {31'd0, ctrl_wb},  {31'd0, pipe[2].wr});
      chk({tag, ".cnt"},      {{(32-CNT_W){1'b0}}, stall_cnt}, m_cnt);
   endtask

   // One decode cycle: drive, check stall, clock, advance model, check slots.
   task automatic step(input string tag, input logic v, input logic [3:0] rd,
                       input logic wr, input logic ld, input logic [3:0] a,
                       input logic [3:0] b, input logic fl);
      logic exp_st;
      ent_t nw;
      id_valid = v; id_rd = rd; id_wr = wr; id_load = ld;
      id_A = a; id_B = b; flush = fl;
      #1;
      // A load sitting in EX that the decoder reads forces one bubble.
      exp_st = EN && v && !fl && pipe[0].wr && pipe[0].ld &&
               (pipe[0].rd == a || pipe[0].rd == b);
      obs_stall = stall;
      chk({tag, ".stall"}, {31'd0, stall}, {31'd0, exp_st});
      chk({tag, ".no2stall"}, {31'd0, stall & prev_stall}, 32'd0);
      prev_stall = stall;
      @(posedge clk);
      if (fl || exp_st) nw = '{4'd0, 1'b0, 1'b0};
      else              nw = '{rd, wr & v, ld & v};
      pipe[2] = pipe[1];
      pipe[1] = pipe[0];
      pipe[0] = nw;
      if (exp_st && m_cnt < int'(CMAX)) m_cnt++;
      #1;
      chk_outputs(tag);
   endtask

   initial begin
      model_reset();
      #1;
      chk("rst.stall", {31'd0, stall}, 32'd0);
      chk_outputs("rst");
      @(negedge clk); rst_n = 1'b1;

      // Advance: rd=5 through EX, MEM, WB.
      step("adv0", 1, 4'd5, 1, 0, 4'd0, 4'd0, 0);
      chk("adv.ex_rd", {28'd0, ex_rd}, 32'd5);
      chk("adv.ctrl_ex", {31'd0, ctrl_ex}, 32'd1);
      step("adv1", 0, 4'd0, 0, 0, 4'd0, 4'd0, 0);
      chk("adv.mem_rd", {28'd0, mem_rd}, 32'd5);
      step("adv2", 0, 4'd0, 0, 0, 4'd0, 4'd0, 0);
      chk("adv.wb_rd", {28'd0, wb_rd}, 32'd5);
      chk("adv.ctrl_wb", {31'd0, ctrl_wb}, 32'd1);

      // Load-use: load r3, then consumer A=3 B=7 writing r9.
      step("lu0", 1, 4'd3, 1, 1, 4'd0, 4'd0, 0);
      chk("lu.ex_load", {31'd0, ex_load}, 32'd1);
      step("lu1", 1, 4'd9, 1, 0, 4'd3, 4'd7, 0);
      chk("lu.stall", {31'd0, obs_stall}, {31'd0, EN});
      chk("lu.mem_rd", {28'd0, mem_rd}, 32'd3);
      chk("lu.ctrl_mem", {31'd0, ctrl_mem}, 32'd1);
      chk("lu.ex_rd", {28'd0, ex_rd}, EN ? 32'd0 : 32'd9);
      chk("lu.ctrl_ex", {31'd0, ctrl_ex}, EN ? 32'd0 : 32'd1);
      if (EN) begin
         step("lu2", 1, 4'd9, 1, 0, 4'd3, 4'd7, 0);
         chk("lu2.stall", {31'd0, obs_stall}, 32'd0);
         chk("lu2.ex_rd", {28'd0, ex_rd}, 32'd9);
      end
      chk("lu.cnt", {{(32-CNT_W){1'b0}}, stall_cnt}, EN ? 32'd1 : 32'd0);

      // Flush beats stall: load r4 in EX, consumer of r4 flushed.
      step("fl0", 1, 4'd4, 1, 1, 4'd0, 4'd0, 0);
      step("fl1", 1, 4'd6, 1, 0, 4'd4, 4'd4, 1);
      chk("fl.stall", {31'd0, obs_stall}, 32'd0);
      chk("fl.ctrl_ex", {31'd0, ctrl_ex}, 32'd0);
      chk("fl.cnt", {{(32-CNT_W){1'b0}}, stall_cnt}, EN ? 32'd1 : 32'd0);

      // Asynchronous reset mid-cycle with MEM holding a write.
      step("ar0", 1, 4'd2, 1, 1, 4'd0, 4'd0, 0);
      step("ar1", 1, 4'd8, 1, 0, 4'd2, 4'd2, 0);
      #2 rst_n = 1'b0;
      model_reset();
      #1;
      chk("ar.stall", {31'd0, stall}, 32'd0);
      chk_outputs("ar");
      @(negedge clk); rst_n = 1'b1;

      // Saturation: five load-use pairs, A==B so each is one stall.
      for (int k = 0; k < 5; k++) begin
         step("sat.ld", 1, 4'd0, 1, 1, 4'd1, 4'd2, 0);
         step("sat.use", 1, 4'd7, 1, 0, 4'd0, 4'd0, 0);
         chk("sat.cnt", {{(32-CNT_W){1'b0}}, stall_cnt},
             EN ? ((k + 1 > 3) ? 32'd3 : k + 1) : 32'd0);
         if (EN) step("sat.rep", 1, 4'd7, 1, 0, 4'd0, 4'd0, 0);
      end

      // Random traffic over a small register range to provoke hazards.
      for (int n = 0; n < 400; n++) begin
         logic [31:0] r;
         r = $urandom;
         step("rnd", r[0] | r[1], {2'b00, r[3:2]}, r[4], r[5] | r[6],
              {2'b00, r[8:7]}, {2'b00, r[10:9]}, (r[13:11] == 3'd0));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end
endmodule

// File: doc/dest_track.md
DEST_TRACK -- requirements
Module: dest_track

Interface
REQ-001 Parameter CNT_W, default 8: width of the stall-event counter.
REQ-002 clk  input  1  sole clock; all state updates on the rising edge.
REQ-003 rst_n  input  1  reset, asynchronous and active-low.
REQ-004 id_valid  input  1  the decode stage holds a real instruction.
REQ-005 id_rd  input  4  destination register of the decoding instruction.
REQ-006 id_wr  input  1  the decoding instruction writes id_rd.
REQ-007 id_load  input  1  the decoding instruction is a load, with data available at the end of MEM.
REQ-008 id_A, id_B  input  4 each  source register addresses of the decoding instruction.
REQ-009 flush  input  1  squash the decoding instruction, e.g. on a taken branch.
REQ-010 ex_rd, mem_rd, wb_rd  output  4 each  registered destinations of the EX, MEM and WB stages.
REQ-011 ctrl_ex, ctrl_mem, ctrl_wb  output  1 each  registered write-enable of the EX, MEM and WB stages.
REQ-012 ex_load  output  1  the EX-stage instruction is a load.
REQ-013 stall  output  1  combinational; hold PC and IF/ID this cycle.
REQ-014 stall_cnt  output  CNT_W  count of cycles with stall=1.

Function
REQ-015 Three stage slots (EX, MEM, WB) SHALL each hold {rd, ctrl, load} and advance one slot per clock: EX->MEM->WB.
REQ-016 Latency SHALL be one cycle per stage: an id_rd/id_wr accepted at edge n appears on ex_rd/ctrl_ex after edge n, on mem_* after n+1 and on wb_* after n+2.
REQ-017 The EX slot SHALL load {id_rd, id_wr & id_valid, id_load & id_valid} when stall=0 and flush=0.
REQ-018 When flush=1, the EX slot SHALL load a bubble {rd=0, ctrl=0, load=0}; flush has priority over stall.
REQ-019 hazard = ctrl_ex & ex_load & id_valid & (ex_rd==id_A | ex_rd==id_B).
REQ-020 stall = hazard & ~flush.
REQ-021 When stall=1, the EX slot SHALL load a bubble while MEM and WB still advance, so the load moves to MEM and a single stall cycle suffices.
REQ-022 A load followed by an independent instruction SHALL NOT stall; a match between MEM-stage rd and id_A/id_B SHALL NOT stall.
REQ-023 Back-to-back stall requests SHALL NOT occur, because the EX slot holds a bubble after each stall; stall SHALL never be high two cycles in a row.
REQ-024 stall_cnt SHALL increment by 1 on each edge where stall=1, saturating at all-ones (2^CNT_W-1) with no wrap-around.
REQ-025 id_A==id_B matching ex_rd SHALL produce one stall, not two.
REQ-026 Register 0 SHALL have no special treatment: rd=0 with ctrl=1 is a real write and can stall.

Reset
REQ-027 While rst_n=0, all slots SHALL be bubbles: ex_rd, mem_rd and wb_rd = 0; ctrl_ex, ctrl_mem, ctrl_wb and ex_load = 0; stall_cnt = 0.
REQ-028 With all slots cleared, stall SHALL be 0.
REQ-029 Reset asserted mid-stall SHALL clear all slots immediately, independent of clk.
REQ-030 The first edge after rst_n rises SHALL behave as a normal advance.

Configuration
REQ-031 Macro DEST_TRACK_LOAD_STALL_EN.
REQ-032 When DEST_TRACK_LOAD_STALL_EN is defined, REQ-019..REQ-025 apply.
REQ-033 When DEST_TRACK_LOAD_STALL_EN is undefined:
- stall SHALL be constant 0 and stall_cnt constant 0;
- ex_load SHALL still be tracked;
- EX loads per REQ-017/018 only; used in pipelines where loads complete in EX.

Verification
REQ-034 Reset: rst_n=0 mid-run with ctrl_mem=1 -> all outputs 0 within the same cycle; stall=0.
REQ-035 Advance: issue rd=5 wr=1 at cycle 0 -> ex_rd=5/ctrl_ex=1 at cycle 1, mem_rd=5 at cycle 2, wb_rd=5/ctrl_wb=1 at cycle 3.
REQ-036 Load-use: load rd=3, then A=3 B=7 -> stall=1 for exactly one cycle; next cycle ctrl_ex=0, mem_rd=3, ctrl_mem=1, ex_load=0; the instruction then enters EX; stall_cnt=1.
REQ-037 Flush priority: load rd=4 in EX, id_A=4, flush=1 -> stall=0, EX becomes a bubble, stall_cnt unchanged.
REQ-038 Saturation: CNT_W=2, force 5 load-use stalls -> stall_cnt reads 1,2,3,3,3.
REQ-039 Macro undefined: repeat REQ-036 -> stall stays 0; ex_rd=3 with ex_load=1 is followed by the dependent instruction in EX on the next cycle.
